// File: rtl/multi_voice_time_advancer.sv
// ---------------------------------------------------------------------------
// MultiVoiceTimeAdvancer
//
// Purpose:
//   Per-voice note-duration timer for the music player datapath. Each voice
//   loads a duration in beats, counts qualifying beats (beat_i=1 while
//   pause_i=0) down to zero and then spends exactly one cycle in DONE,
//   raising advance_done_o for that voice so its sequencer can fetch the
//   next note. A zero duration goes straight to DONE, and a load seen while
//   in DONE reloads immediately so consecutive notes have no idle gap.
//
// Optional feature:
//   TIME_ADVANCER_RETRIGGER_EN - when defined, a load arriving while a voice
//   is counting restarts that voice with the new duration (no done pulse for
//   the interrupted note). When undefined, loads during counting are ignored.
//
// Ports:
//   clk_i           - sole clock, rising-edge active
//   reset_i         - synchronous, active-low reset of every voice
//   duration_i      - packed per-voice durations, voice i at [i*DUR_WIDTH +: DUR_WIDTH]
//   load_i          - per-voice load request, level-sampled every edge
//   beat_i          - one-cycle tempo tick shared by all voices
//   pause_i         - when high, beats are ignored by every voice
//   advance_done_o  - per-voice, high for the single cycle the voice is in DONE
//   busy_o          - per-voice, high while the voice is in COUNT
//   all_idle_o      - high when every voice is in IDLE
//   remaining_o     - packed per-voice current count, same layout as duration_i
// ---------------------------------------------------------------------------
module multi_voice_time_advancer #(
    parameter int NUM_VOICES = 3,
    parameter int DUR_WIDTH  = 6
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [NUM_VOICES*DUR_WIDTH-1:0]   duration_i,
    input  logic [NUM_VOICES-1:0]             load_i,
    input  logic                              beat_i,
    input  logic                              pause_i,
    output logic [NUM_VOICES-1:0]             advance_done_o,
    output logic [NUM_VOICES-1:0]             busy_o,
    output logic                              all_idle_o,
    output logic [NUM_VOICES*DUR_WIDTH-1:0]   remaining_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [DUR_WIDTH-1:0] ZERO = '0;
    localparam logic [DUR_WIDTH-1:0] ONE  = {{(DUR_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q [NUM_VOICES];
    state_t               state_d [NUM_VOICES];
    logic [DUR_WIDTH-1:0] count_q [NUM_VOICES];
    logic [DUR_WIDTH-1:0] count_d [NUM_VOICES];

    // Outcome of a load and of a beat, computed once per voice so the state
    // case below only has to pick between them.
    state_t               loadState [NUM_VOICES];
    logic [DUR_WIDTH-1:0] loadCount [NUM_VOICES];
    state_t               tickState [NUM_VOICES];
    logic [DUR_WIDTH-1:0] tickCount [NUM_VOICES];

    logic beatOk;

    assign beatOk = beat_i & ~pause_i;

    // Next-state logic for every voice. A load ignores any beat on the same
    // edge, so the freshly loaded count is never decremented immediately.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];

            loadCount[i] = duration_i[i*DUR_WIDTH +: DUR_WIDTH];
            loadState[i] = (loadCount[i] == ZERO) ? ST_DONE : ST_COUNT;

            // Count is at least 1 in COUNT, so reaching 1 ends the note and
            // the subtraction can never wrap.
            if (count_q[i] == ONE) begin
                tickState[i] = ST_DONE;
                tickCount[i] = ZERO;
            end else begin
                tickState[i] = ST_COUNT;
                tickCount[i] = count_q[i] - ONE;
            end

            case (state_q[i])
                ST_IDLE: begin
                    if (load_i[i]) begin
                        state_d[i] = loadState[i];
                        count_d[i] = loadCount[i];
                    end else begin
                        count_d[i] = ZERO;
                    end
                end
                ST_COUNT: begin
`ifdef TIME_ADVANCER_RETRIGGER_EN
                    if (load_i[i]) begin
                        state_d[i] = loadState[i];
                        count_d[i] = loadCount[i];
                    end else if (beatOk) begin
                        state_d[i] = tickState[i];
                        count_d[i] = tickCount[i];
                    end
`else
                    if (beatOk) begin
                        state_d[i] = tickState[i];
                        count_d[i] = tickCount[i];
                    end
`endif
                end
                ST_DONE: begin
                    if (load_i[i]) begin
                        state_d[i] = loadState[i];
                        count_d[i] = loadCount[i];
                    end else begin
                        state_d[i] = ST_IDLE;
                        count_d[i] = ZERO;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    count_d[i] = ZERO;
                end
            endcase
        end
    end

    // State and count registers; the active-low reset wins over every other
    // input on the same edge.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!reset_i) begin
                state_q[i] <= ST_IDLE;
                count_q[i] <= ZERO;
            end else begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        advance_done_o = '0;
        busy_o         = '0;
        remaining_o    = '0;
        all_idle_o     = 1'b1;
        for (int i = 0; i < NUM_VOICES; i++) begin
            advance_done_o[i] = (state_q[i] == ST_DONE);
            busy_o[i]         = (state_q[i] == ST_COUNT);
            remaining_o[i*DUR_WIDTH +: DUR_WIDTH] = count_q[i];
            if (state_q[i] != ST_IDLE) begin
                all_idle_o = 1'b0;
            end
        end
    end

endmodule

// File: doc/multi_voice_time_advancer.md
# multi_voice_time_advancer

Parametrised multi-channel note-duration timer for the music player datapath. Each voice loads a duration in beats, counts qualifying `beat` pulses down to zero, and raises a one-cycle `advance_done` for that voice so its note sequencer can fetch the next note. It adds a global pause, a zero-duration fast path, back-to-back reload from DONE and an optional retrigger mode over the single-voice advancer.

## Interface
- `NUM_VOICES`, default 3: number of independent voice timers.
- `DUR_WIDTH`, default 6: duration width in beats; maximum duration is 2^DUR_WIDTH-1.
- `clk` in, 1 bit: sole clock; all state updates on its rising edge.
- `reset` in, 1 bit: synchronous, active-low; 0 sampled at a rising edge resets all voices.
- `duration` in, NUM_VOICES*DUR_WIDTH bits: per-voice duration; voice i uses bits [i*DUR_WIDTH +: DUR_WIDTH].
- `load` in, NUM_VOICES bits: per-voice load request, level-sampled each edge.
- `beat` in, 1 bit: one-cycle tempo tick shared by all voices.
- `pause` in, 1 bit: when 1, beats are ignored by every voice.
- `advance_done` out, NUM_VOICES bits: bit i is 1 for exactly the cycle voice i is in DONE.
- `busy` out, NUM_VOICES bits: bit i is 1 while voice i is in COUNT.
- `all_idle` out, 1 bit: 1 when every voice is in IDLE.
- `remaining` out, NUM_VOICES*DUR_WIDTH bits: per-voice current count, for debug and display.

## Operation
- Per-voice Moore FSM with states IDLE, COUNT and DONE, plus a DUR_WIDTH-bit count register. Voices are fully independent apart from the shared `beat`, `pause` and `reset`.
- A qualifying beat is `beat`=1 and `pause`=0 sampled at the same edge.
- IDLE:
  - `load[i]`=1 with duration D>0: count <= D, go to COUNT.
  - `load[i]`=1 with D=0: go directly to DONE, count <= 0.
  - Otherwise stay in IDLE; count holds 0.
- COUNT:
  - Qualifying beat with count=1: count <= 0, go to DONE.
  - Qualifying beat with count>1: count <= count-1.
  - No qualifying beat: hold.
  - `load[i]` in COUNT is governed by the Configuration section.
- DONE lasts exactly one cycle:
  - `load[i]`=1: reload, same rules as IDLE. This allows back-to-back notes with no IDLE gap.
  - Otherwise go to IDLE with count <= 0.
- A beat sampled in the same edge as a load is not applied to the newly loaded count.
- Arithmetic is unsigned DUR_WIDTH-bit. The count never decrements below 1 in COUNT, so it cannot wrap.
- Out-of-range state encodings recover to IDLE with count 0 on the next edge.

## Timing
- Reset value: every voice in IDLE with count 0.
  - `advance_done`=0, `busy`=0, `remaining`=0, `all_idle`=1.
- Reset dominates `load`, `beat` and `pause` in the same edge. Reset mid-count aborts the voice with no done pulse.
- All outputs are registered-state decodes: no combinational path from any input to any output.
- With D>0, load sampled at edge k:
  - `busy` rises in cycle k+1.
  - `advance_done` is high in the cycle following the edge that samples the D-th qualifying beat.
- With D=0, `advance_done` is high in cycle k+1 and `busy` never rises.
- Minimum note period is 2 cycles (COUNT to DONE). A reload from DONE re-enters COUNT with no gap.
- `pause` freezes counts but not state transitions already due: DONE still exits to IDLE or reloads.

## Configuration
- `TIME_ADVANCER_RETRIGGER_EN` defined:
  - `load[i]`=1 in COUNT reloads count with the new duration and stays in COUNT, or goes to DONE if D=0.
  - Load wins over a simultaneous beat.
  - No done pulse is issued for the interrupted note.
- Not defined: `load[i]` in COUNT is ignored and the count proceeds unchanged.

## Test plan
- Reset, then voice 0 loads D=3 with a beat every 4 cycles: `busy[0]` rises the next cycle, `remaining` goes 3→2→1→0, and `advance_done[0]` pulses for 1 cycle after the 3rd beat. Other voices stay idle.
- Voice 1 loads D=0: `advance_done[1]` pulses in the next cycle, `busy[1]` stays 0 throughout.
- Voice 2 loads D=2, with `pause`=1 held over 5 beats and then released: `remaining` holds at 2 while paused, and done follows the 2nd unpaused beat.
- `load[0]` held high continuously with D=1 and beats every cycle: DONE→COUNT reload repeats, giving a done pulse every 2 cycles and `all_idle`=0 throughout.
- Voice 0 loads D=5, then after 2 beats `load[0]` is asserted with D=4:
  - With the macro: `remaining`=4 and done comes after 4 more beats.
  - Without the macro: done comes after 3 more beats.
- All 3 voices are counting when `reset`=0 for one edge: all outputs return to reset values the next cycle with no done pulse, and `all_idle`=1.
